// File: rtl/ib32bit_pc_if.sv
// Bus between the control/branch unit (master) and the program counter (slave).
// Carries jump/branch/stall requests in and the registered PC plus return address out.
interface ib32bit_pc_if #(
  parameter int AWIDTH = 6
);
  logic [AWIDTH-1:0] addr;
  logic              load;
  logic              branch;
  logic [AWIDTH-1:0] offset;
  logic              stall;
  logic [AWIDTH-1:0] addr_out;
  logic [AWIDTH-1:0] addr_next;
  logic              wrap;

  modport master (
    output addr, load, branch, offset, stall,
    input  addr_out, addr_next, wrap
  );

  modport slave (
    input  addr, load, branch, offset, stall,
    output addr_out, addr_next, wrap
  );
endinterface

// File: rtl/ib32bit_pc.sv
// Instruction-memory program counter: hold / absolute load / relative branch / increment.
// Optional macro IB_PC_HALT_EN turns wrap-around into a saturating halt with a sticky wrap flag.
module ib32bit_pc #(
  parameter int AWIDTH = 6
) (
  input logic         clk,
  input logic         rst,
  ib32bit_pc_if.slave bus
);
  typedef logic [AWIDTH-1:0] addr_t;

  function automatic addr_t incr(input addr_t a);
    return a + addr_t'(1);
  endfunction

  function automatic logic incr_wraps(input addr_t a);
    return &a;
  endfunction

  // offset is sign-extended only here; the PC itself is unsigned, so two guard bits hold the sum.
  function automatic logic branch_ovf(input addr_t a, input addr_t off);
    logic signed [AWIDTH+1:0] s;
    s = $signed({2'b00, a}) + $signed({{2{off[AWIDTH-1]}}, off});
    return s[AWIDTH+1] | s[AWIDTH];
  endfunction

  addr_t pc_p0;
  logic  wrap_p0;
  addr_t pc_d;
  logic  wrap_d;

  always_comb begin
    pc_d   = pc_p0;
    wrap_d = 1'b0;
`ifdef IB_PC_HALT_EN
    if (bus.stall) begin
      wrap_d = wrap_p0;
    end else if (bus.load) begin
      pc_d = bus.addr;
    end else if (wrap_p0) begin
      wrap_d = 1'b1;
    end else if (bus.branch) begin
      if (branch_ovf(pc_p0, bus.offset)) begin
        wrap_d = 1'b1;
      end else begin
        pc_d = pc_p0 + bus.offset;
      end
    end else begin
      if (incr_wraps(pc_p0)) begin
        wrap_d = 1'b1;
      end else begin
        pc_d = incr(pc_p0);
      end
    end
`else
    if (bus.stall) begin
      pc_d = pc_p0;
    end else if (bus.load) begin
      pc_d = bus.addr;
    end else if (bus.branch) begin
      pc_d   = pc_p0 + bus.offset;
      wrap_d = branch_ovf(pc_p0, bus.offset);
    end else begin
      pc_d   = incr(pc_p0);
      wrap_d = incr_wraps(pc_p0);
    end
`endif
  end

  // p0: the architectural PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0   <= '0;
      wrap_p0 <= 1'b0;
    end else begin
      pc_p0   <= pc_d;
      wrap_p0 <= wrap_d;
    end
  end

  assign bus.addr_out  = pc_p0;
  assign bus.addr_next = incr(pc_p0);
  assign bus.wrap      = wrap_p0;
endmodule

// File: tb/tb_ib32bit_pc.sv
// Directed and randomized bench for ib32bit_pc against an arithmetic reference model.
module tb_ib32bit_pc;
  localparam int AW  = 6;
  localparam int TOP = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   mpc = 0;
  int   mw  = 0;

  ib32bit_pc_if #(.AWIDTH(AW)) bus ();

  ib32bit_pc #(.AWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic l, input logic [AW-1:0] a,
                       input logic b, input logic [AW-1:0] o, input logic s);
    int sum;
    if (r === 1'b1) begin
      mpc = 0; mw = 0;
    end else if (s === 1'b1) begin
`ifndef IB_PC_HALT_EN
      mw = 0;
`endif
    end else if (l === 1'b1) begin
      mpc = int'(a); mw = 0;
`ifdef IB_PC_HALT_EN
    end else if (mw == 1) begin
      mw = 1;
`endif
    end else if (b === 1'b1) begin
      sum = mpc + int'($signed(o));
`ifdef IB_PC_HALT_EN
      if (sum < 0 || sum >= TOP) mw = 1;
      else mpc = sum;
`else
      mw  = (sum < 0 || sum >= TOP) ? 1 : 0;
      mpc = (sum + TOP) % TOP;
`endif
    end else begin
      sum = mpc + 1;
`ifdef IB_PC_HALT_EN
      if (sum == TOP) mw = 1;
      else mpc = sum;
`else
      mw  = (sum == TOP) ? 1 : 0;
      mpc = sum % TOP;
`endif
    end
  endtask

  // exp_pc / exp_w of -1 mean "no directed expectation", only the model is compared
  task automatic step(input logic r, input logic l, input logic [AW-1:0] a,
                      input logic b, input logic [AW-1:0] o, input logic s,
                      input string tag, input int exp_pc, input int exp_w);
    rst = r; bus.load = l; bus.addr = a; bus.branch = b; bus.offset = o; bus.stall = s;
    @(posedge clk);
    model(r, l, a, b, o, s);
    #1;
    chk({tag, ".pc"},   32'(bus.addr_out),  32'(mpc));
    chk({tag, ".next"}, 32'(bus.addr_next), 32'((mpc + 1) % TOP));
    chk({tag, ".wrap"}, 32'(bus.wrap),      32'(mw));
    if (exp_pc >= 0) chk({tag, ".pc_dir"}, 32'(bus.addr_out), 32'(exp_pc));
    if (exp_w >= 0)  chk({tag, ".wrap_dir"}, 32'(bus.wrap), 32'(exp_w));
  endtask

  initial begin
    logic [AW-1:0] xa;
    logic          r, l, b, s;
    logic [AW-1:0] a, o;
    xa = 'x;
    bus.load = 1'b0; bus.branch = 1'b0; bus.stall = 1'b0; bus.addr = xa; bus.offset = xa;

    for (int i = 0; i < 10; i++) step(1, 0, xa, 0, xa, 0, "reset", 0, 0);
    for (int i = 0; i < 5; i++)  step(0, 0, xa, 0, xa, 0, "release", i + 1, 0);

    step(0, 1, 6'd62, 1'bx, xa, 0, "ld62", 62, 0);
    step(0, 0, xa, 0, xa, 0, "inc63", 63, 0);
`ifdef IB_PC_HALT_EN
    step(0, 0, xa, 0, xa, 0, "halt1", 63, 1);
    step(0, 0, xa, 0, xa, 0, "halt2", 63, 1);
`else
    step(0, 0, xa, 0, xa, 0, "wrap0", 0, 1);
    step(0, 0, xa, 0, xa, 0, "wrap1", 1, 0);
`endif

    step(0, 1, 6'd10, 0, xa, 0, "ld10", 10, 0);
    step(0, 0, xa, 1, 6'b111101, 0, "br_m3", 7, 0);
    step(0, 0, xa, 1, 6'd5, 0, "br_p5", 12, 0);
    step(0, 1, 6'd60, 0, xa, 0, "ld60", 60, 0);
`ifdef IB_PC_HALT_EN
    step(0, 0, xa, 1, 6'd8, 0, "br_ovf", 60, 1);
    step(0, 1, 6'd20, 1, 6'd3, 1, "prio_stall", 60, 1);
`else
    step(0, 0, xa, 1, 6'd8, 0, "br_ovf", 4, 1);
    step(0, 1, 6'd20, 1, 6'd3, 1, "prio_stall", 4, 0);
`endif
    step(0, 1, 6'd20, 1, 6'd3, 0, "prio_load", 20, 0);
    step(1, 1, 6'd33, 1, 6'd3, 1, "prio_rst", 0, 0);

    step(0, 1, 6'd9, 0, xa, 0, "ld9", 9, 0);
    for (int i = 0; i < 4; i++) step(0, 0, xa, 1'bx, xa, 1, "stall", 9, 0);
    step(0, 0, xa, 0, xa, 0, "unstall", 10, 0);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 3) == 0);
      a = l ? AW'($urandom) : xa;
      o = b ? AW'($urandom) : xa;
      if (l && $urandom_range(0, 1) == 1) b = 1'bx;
      step(r, l, a, b, o, s, "rand", -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
